wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order pipeline writeback (WB) and a long-latency multiply/divide unit (MDU) that returns results out of order.
- Keeps a per-register scoreboard of MDU destinations still in flight, and raises a decode stall on RAW or WAW hazards against them.
- Sits between the WB stage, the MDU and the decode stage. Its write-port outputs drive decode's rdD_data_i / rdD_addr_i / rdD_wr_ena_i directly.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/wb_scoreboard.sv | 51 +++++
 rtl/wb_port_arbiter.sv | 135 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core definitions.
//   XLEN                - integer register width.
//   MDU_MAX_OUTSTANDING - multiply/divide ops that may be in flight at once.
//   wb_req_t            - one register-file write request {ena, addr, data}.
package riscv_pkg;

  localparam int unsigned XLEN                = 32;
  localparam int unsigned MDU_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic            ena;
    logic [4:0]      addr;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: one bit per architectural register, set while an MDU op
// targeting it is in flight.
//   clk_i, rstn_i           - clock, asynchronous active-low reset.
//   set_ena_i / set_rd_i    - MDU op issued to set_rd_i.
//   clr_ena_i / clr_rd_i    - MDU result for clr_rd_i is written this cycle.
//   rs1/rs2/rd_addr_i       - registers of the instruction in decode.
//   hazard_o                - decode touches a register still in flight.
//   sb_o                    - current scoreboard (bit 0 always 0).
module wb_scoreboard (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        set_ena_i,
  input  logic [4:0]  set_rd_i,
  input  logic        clr_ena_i,
  input  logic [4:0]  clr_rd_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  input  logic [4:0]  rd_addr_i,
  output logic        hazard_o,
  output logic [31:0] sb_o
);

  logic [31:1] sb_q;
  logic [31:0] sb_d;
  logic [31:0] clr_mask;
  logic [31:0] live;

  assign sb_o     = {sb_q, 1'b0};
  assign clr_mask = clr_ena_i ? (32'd1 << clr_rd_i) : '0;

  // Set is applied after clear so a reissue to the register being retired
  // keeps it marked busy.
  always_comb begin
    sb_d = {sb_q, 1'b0};
    sb_d = sb_d & ~clr_mask;
    if (set_ena_i && (set_rd_i != 5'd0)) sb_d[set_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) sb_q <= '0;
    else         sb_q <= sb_d[31:1];
  end

  // The register being written this cycle is not a hazard: the register
  // file writes on negedge, so decode already sees the new value.
  // Bit 0 of live is always 0, which covers the x0 case for free.
  assign live     = {sb_q, 1'b0} & ~clr_mask;
  assign hazard_o = live[rs1_addr_i] | live[rs2_addr_i] | live[rd_addr_i];

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the in-order
// writeback stage and out-of-order MDU results, and stalls decode on
// hazards against MDU destinations still in flight.
//   clk_i, rstn_i                          - clock, async active-low reset.
//   wb_wr_ena_i/wb_rd_addr_i/wb_rd_data_i  - WB write request.
//   wb_stall_o                             - WB lost the port, retry.
//   issue_valid_i/issue_rd_i/issue_ready_o - MDU op issue handshake.
//   mdu_valid_i/mdu_rd_i/mdu_data_i/mdu_ready_o - MDU result handshake.
//   rs1D/rs2D/rdD_addr_i, sb_stall_o       - decode hazard check.
//   rf_wr_ena_o/rf_wr_addr_o/rf_wr_data_o  - register-file write port.
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT        = 4,
  parameter int unsigned MAX_OUTSTANDING = MDU_MAX_OUTSTANDING
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            wb_wr_ena_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic [XLEN-1:0] wb_rd_data_i,
  output logic            wb_stall_o,
  input  logic            issue_valid_i,
  input  logic [4:0]      issue_rd_i,
  output logic            issue_ready_o,
  input  logic            mdu_valid_i,
  input  logic [4:0]      mdu_rd_i,
  input  logic [XLEN-1:0] mdu_data_i,
  output logic            mdu_ready_o,
  input  logic [4:0]      rs1D_addr_i,
  input  logic [4:0]      rs2D_addr_i,
  input  logic [4:0]      rdD_addr_i,
  output logic            sb_stall_o,
  output logic            rf_wr_ena_o,
  output logic [4:0]      rf_wr_addr_o,
  output logic [XLEN-1:0] rf_wr_data_o
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned PEND_W = $clog2(MAX_OUTSTANDING + 1);

  wb_req_t           hold_q;       // ena doubles as the buffer-valid flag
  wb_req_t           port_req;
  logic [WAIT_W-1:0] wait_cnt;
  logic [PEND_W-1:0] pending_cnt;
  logic              wb_busy;
  logic              mdu_grant;
  logic              mdu_accept;
  logic              issue_acc;
  logic [31:0]       sb_vec;

  assign wb_busy       = wb_wr_ena_i && (wb_rd_addr_i != 5'd0);
  assign mdu_grant     = hold_q.ena && (!wb_busy || (wait_cnt == WAIT_W'(MAX_WAIT)));
  assign mdu_ready_o   = !hold_q.ena || mdu_grant;
  assign mdu_accept    = mdu_valid_i && mdu_ready_o;
  assign issue_ready_o = pending_cnt < PEND_W'(MAX_OUTSTANDING);
  assign issue_acc     = issue_valid_i && issue_ready_o;
  assign wb_stall_o    = mdu_grant && wb_busy;

  always_comb begin
    port_req = '0;
    if (mdu_grant) begin
      port_req.ena  = hold_q.addr != 5'd0;
      port_req.addr = hold_q.addr;
      port_req.data = hold_q.data;
    end else begin
      port_req.ena  = wb_busy;
      port_req.addr = wb_rd_addr_i;
      port_req.data = wb_rd_data_i;
    end
  end

  assign rf_wr_ena_o  = port_req.ena;
  assign rf_wr_addr_o = port_req.addr;
  assign rf_wr_data_o = port_req.data;

  // Capture has priority over drain: a new result may land in the same
  // edge the old one is granted, so back-to-back results see no bubble.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      hold_q <= '0;
    end else if (mdu_accept) begin
      hold_q.ena  <= 1'b1;
      hold_q.addr <= mdu_rd_i;
      hold_q.data <= mdu_data_i;
    end else if (mdu_grant) begin
      hold_q.ena <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wait_cnt <= '0;
    end else if (!hold_q.ena || mdu_grant) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_cnt <= '0;
    end else begin
      case ({issue_acc, mdu_grant})
        2'b10:   pending_cnt <= pending_cnt + PEND_W'(1);
        2'b01:   pending_cnt <= pending_cnt - PEND_W'(1);
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  wb_scoreboard u_sb (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .set_ena_i  (issue_acc),
    .set_rd_i   (issue_rd_i),
    .clr_ena_i  (mdu_grant),
    .clr_rd_i   (hold_q.addr),
    .rs1_addr_i (rs1D_addr_i),
    .rs2_addr_i (rs2D_addr_i),
    .rd_addr_i  (rdD_addr_i),
    .hazard_o   (sb_stall_o),
    .sb_o       (sb_vec)
  );

  a_issue_when_full: assert property (@(posedge clk_i) disable iff (!rstn_i)
    !(issue_valid_i && !issue_ready_o))
    else $error("MDU issue while %0d ops already outstanding", MAX_OUTSTANDING);

  a_orphan_result: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (mdu_grant && (hold_q.addr != 5'd0)) |-> sb_vec[hold_q.addr])
    else $error("MDU result for x%0d with no scoreboard entry", hold_q.addr);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: bench for wb_port_arbiter.
module tb_wb_port_arbiter;
  import riscv_pkg::*;

  logic            clk_i = 1'b0;
  logic            rstn_i;
  logic            wb_wr_ena_i;
  logic [4:0]      wb_rd_addr_i;
  logic [XLEN-1:0] wb_rd_data_i;
  logic            wb_stall_o;
  logic            issue_valid_i;
  logic [4:0]      issue_rd_i;
  logic            issue_ready_o;
  logic            mdu_valid_i;
  logic [4:0]      mdu_rd_i;
  logic [XLEN-1:0] mdu_data_i;
  logic            mdu_ready_o;
  logic [4:0]      rs1D_addr_i, rs2D_addr_i, rdD_addr_i;
  logic            sb_stall_o;
  logic            rf_wr_ena_o;
  logic [4:0]      rf_wr_addr_o;
  logic [XLEN-1:0] rf_wr_data_o;

  int total  = 0;
  int passed = 0;

  always #5 clk_i = ~clk_i;

  wb_port_arbiter #(.MAX_WAIT(4), .MAX_OUTSTANDING(4)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .wb_wr_ena_i   (wb_wr_ena_i),
    .wb_rd_addr_i  (wb_rd_addr_i),
    .wb_rd_data_i  (wb_rd_data_i),
    .wb_stall_o    (wb_stall_o),
    .issue_valid_i (issue_valid_i),
    .issue_rd_i    (issue_rd_i),
    .issue_ready_o (issue_ready_o),
    .mdu_valid_i   (mdu_valid_i),
    .mdu_rd_i      (mdu_rd_i),
    .mdu_data_i    (mdu_data_i),
    .mdu_ready_o   (mdu_ready_o),
    .rs1D_addr_i   (rs1D_addr_i),
    .rs2D_addr_i   (rs2D_addr_i),
    .rdD_addr_i    (rdD_addr_i),
    .sb_stall_o    (sb_stall_o),
    .rf_wr_ena_o   (rf_wr_ena_o),
    .rf_wr_addr_o  (rf_wr_addr_o),
    .rf_wr_data_o  (rf_wr_data_o)
  );

  task automatic idle_inputs();
    wb_wr_ena_i = 0; wb_rd_addr_i = 0; wb_rd_data_i = 0;
    issue_valid_i = 0; issue_rd_i = 0;
    mdu_valid_i = 0; mdu_rd_i = 0; mdu_data_i = 0;
    rs1D_addr_i = 0; rs2D_addr_i = 0; rdD_addr_i = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    idle_inputs();
    rstn_i = 0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn_i = 0;
    #3;
    total++; if ({wb_stall_o, issue_ready_o, mdu_ready_o, sb_stall_o} !== 4'b0110)
      $display("FAIL reset_flags: got %b want 0110", {wb_stall_o, issue_ready_o, mdu_ready_o, sb_stall_o}); else passed++;
    total++; if ({rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o} !== '0)
      $display("FAIL reset_port: got ena=%b addr=%0d data=%h want all 0", rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o); else passed++;
    apply_reset();
  endtask

  task automatic test_wb_only();
    apply_reset();
    wb_wr_ena_i = 1; wb_rd_addr_i = 5; wb_rd_data_i = 32'h1234;
    #1;
    total++; if ({rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o} !== {1'b1, 5'd5, 32'h1234})
      $display("FAIL wb_only_port: got ena=%b x%0d=%h want 1 x5=1234", rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o); else passed++;
    total++; if ({wb_stall_o, sb_stall_o} !== 2'b00)
      $display("FAIL wb_only_stalls: got %b want 00", {wb_stall_o, sb_stall_o}); else passed++;
    @(negedge clk_i);
    wb_rd_addr_i = 0; wb_rd_data_i = 32'h5555;
    #1;
    total++; if (rf_wr_ena_o !== 1'b0)
      $display("FAIL wb_x0_write: got ena=%b want 0", rf_wr_ena_o); else passed++;
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_mdu_idle();
    apply_reset();
    issue_valid_i = 1; issue_rd_i = 7;
    @(negedge clk_i);
    issue_valid_i = 0; rs1D_addr_i = 7;
    #1;
    total++; if (sb_stall_o !== 1'b1)
      $display("FAIL mdu_raw_stall: got %b want 1", sb_stall_o); else passed++;
    mdu_valid_i = 1; mdu_rd_i = 7; mdu_data_i = 32'hDEAD;
    #1;
    total++; if ({mdu_ready_o, rf_wr_ena_o} !== 2'b10)
      $display("FAIL mdu_accept_cycle: got ready/ena=%b want 10", {mdu_ready_o, rf_wr_ena_o}); else passed++;
    @(negedge clk_i);
    mdu_valid_i = 0;
    #1;
    total++; if ({rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o} !== {1'b1, 5'd7, 32'hDEAD})
      $display("FAIL mdu_write: got ena=%b x%0d=%h want 1 x7=dead", rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o); else passed++;
    total++; if (sb_stall_o !== 1'b0)
      $display("FAIL mdu_bypass: got sb_stall=%b want 0", sb_stall_o); else passed++;
    @(negedge clk_i);
    #1;
    total++; if ({sb_stall_o, rf_wr_ena_o} !== 2'b00)
      $display("FAIL mdu_sb_cleared: got sb_stall/ena=%b want 00", {sb_stall_o, rf_wr_ena_o}); else passed++;
    idle_inputs();
  endtask

  task automatic test_starvation();
    apply_reset();
    issue_valid_i = 1; issue_rd_i = 9;
    @(negedge clk_i);
    issue_valid_i = 0; mdu_valid_i = 1; mdu_rd_i = 9; mdu_data_i = 32'h9999;
    @(negedge clk_i);
    mdu_valid_i = 0;
    wb_wr_ena_i = 1; wb_rd_addr_i = 10;
    for (int k = 1; k <= 4; k++) begin
      wb_rd_data_i = k;
      #1;
      total++; if ({wb_stall_o, rf_wr_addr_o, rf_wr_data_o} !== {1'b0, 5'd10, 32'(k)})
        $display("FAIL starve_wb_wins_%0d: got stall=%b x%0d=%h want 0 x10=%h", k, wb_stall_o, rf_wr_addr_o, rf_wr_data_o, k); else passed++;
      @(negedge clk_i);
    end
    wb_rd_data_i = 5;
    #1;
    total++; if ({wb_stall_o, rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o} !== {2'b11, 5'd9, 32'h9999})
      $display("FAIL starve_forced: got stall=%b ena=%b x%0d=%h want 1 1 x9=9999", wb_stall_o, rf_wr_ena_o, rf_wr_addr_o, rf_wr_data_o); else passed++;
    @(negedge clk_i);
    #1;
    total++; if ({wb_stall_o, rf_wr_addr_o, rf_wr_data_o} !== {1'b0, 5'd10, 32'd5})
      $display("FAIL starve_retry: got stall=%b x%0d=%h want 0 x10=5", wb_stall_o, rf_wr_addr_o, rf_wr_data_o); else passed++;
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_capacity();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1; issue_rd_i = 5'(11 + i);
      #1;
      total++; if (issue_ready_o !== 1'b1)
        $display("FAIL cap_ready_%0d: got %b want 1", i, issue_ready_o); else passed++;
      @(negedge clk_i);
    end
    issue_valid_i = 0;
    #1;
    total++; if (issue_ready_o !== 1'b0)
      $display("FAIL cap_full: got %b want 0", issue_ready_o); else passed++;
    mdu_valid_i = 1; mdu_rd_i = 11; mdu_data_i = 32'h11;
    @(negedge clk_i);
    mdu_valid_i = 0;
    #1;
    total++; if ({issue_ready_o, rf_wr_addr_o} !== {1'b0, 5'd11})
      $display("FAIL cap_grant_cycle: got ready=%b x%0d want 0 x11", issue_ready_o, rf_wr_addr_o); else passed++;
    @(negedge clk_i);
    #1;
    total++; if (issue_ready_o !== 1'b1)
      $display("FAIL cap_after_grant: got %b want 1", issue_ready_o); else passed++;
    mdu_valid_i = 1; mdu_rd_i = 12; mdu_data_i = 32'h12;
    @(negedge clk_i);
    mdu_valid_i = 0; issue_valid_i = 1; issue_rd_i = 15;
    #1;
    total++; if ({rf_wr_ena_o, rf_wr_addr_o} !== {1'b1, 5'd12})
      $display("FAIL cap_issue_and_grant: got ena=%b x%0d want 1 x12", rf_wr_ena_o, rf_wr_addr_o); else passed++;
    @(negedge clk_i);
    issue_rd_i = 16;
    #1;
    total++; if (issue_ready_o !== 1'b1)
      $display("FAIL cap_three_left: got %b want 1", issue_ready_o); else passed++;
    @(negedge clk_i);
    issue_valid_i = 0;
    #1;
    total++; if (issue_ready_o !== 1'b0)
      $display("FAIL cap_full_again: got %b want 0", issue_ready_o); else passed++;
    idle_inputs();
  endtask

  task automatic test_same_reg();
    apply_reset();
    issue_valid_i = 1; issue_rd_i = 3;
    @(negedge clk_i);
    issue_valid_i = 0; mdu_valid_i = 1; mdu_rd_i = 3; mdu_data_i = 32'h3333;
    @(negedge clk_i);
    mdu_valid_i = 0; issue_valid_i = 1; issue_rd_i = 3; rs1D_addr_i = 3;
    #1;
    total++; if ({rf_wr_addr_o, sb_stall_o} !== {5'd3, 1'b0})
      $display("FAIL reissue_grant: got x%0d sb_stall=%b want x3 0", rf_wr_addr_o, sb_stall_o); else passed++;
    @(negedge clk_i);
    issue_valid_i = 0;
    #1;
    total++; if (sb_stall_o !== 1'b1)
      $display("FAIL reissue_set_wins: got sb_stall=%b want 1", sb_stall_o); else passed++;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    issue_valid_i = 1; issue_rd_i = 4;
    @(negedge clk_i);
    issue_rd_i = 5;
    @(negedge clk_i);
    issue_valid_i = 0; mdu_valid_i = 1; mdu_rd_i = 4; mdu_data_i = 32'h4444;
    @(negedge clk_i);
    mdu_valid_i = 0; rdD_addr_i = 5;
    #1;
    total++; if ({rf_wr_ena_o, sb_stall_o} !== 2'b11)
      $display("FAIL midrst_pre: got ena/sb_stall=%b want 11", {rf_wr_ena_o, sb_stall_o}); else passed++;
    #1;
    rstn_i = 0;
    #1;
    total++; if ({wb_stall_o, issue_ready_o, mdu_ready_o, sb_stall_o, rf_wr_ena_o} !== 5'b01100)
      $display("FAIL midrst_flags: got %b want 01100", {wb_stall_o, issue_ready_o, mdu_ready_o, sb_stall_o, rf_wr_ena_o}); else passed++;
    total++; if ({rf_wr_addr_o, rf_wr_data_o} !== '0)
      $display("FAIL midrst_port: got x%0d=%h want 0", rf_wr_addr_o, rf_wr_data_o); else passed++;
    @(negedge clk_i);
    rstn_i = 1;
    for (int i = 0; i < 4; i++) begin
      issue_valid_i = 1; issue_rd_i = 5'(20 + i);
      #1;
      total++; if ({rf_wr_ena_o, issue_ready_o} !== 2'b01)
        $display("FAIL midrst_after_%0d: got ena/ready=%b want 01", i, {rf_wr_ena_o, issue_ready_o}); else passed++;
      @(negedge clk_i);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit             m_valid;
    logic [4:0]     m_rd;
    logic [31:0]    m_data;
    int             m_yield;
    bit             m_sb[32];
    int             m_pend;
    int             mdu_q[$];
    bit             hold_v;
    logic [4:0]     hold_rd;
    logic [31:0]    hold_data;
    bit             wb_wants, forced, e_ena, e_wbst, e_mrdy, e_irdy, e_sbst;
    logic [4:0]     e_addr, r;
    logic [31:0]    e_data;
    int             idx;
    logic [4:0]     dregs[3];

    apply_reset();
    m_valid = 0; m_rd = 0; m_data = 0; m_yield = 0; m_pend = 0; hold_v = 0;
    hold_rd = 0; hold_data = 0;
    foreach (m_sb[i]) m_sb[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!hold_v && mdu_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, mdu_q.size() - 1);
        hold_rd = 5'(mdu_q[idx]);
        mdu_q.delete(idx);
        hold_data = $urandom;
        hold_v = 1;
      end
      mdu_valid_i = hold_v; mdu_rd_i = hold_rd; mdu_data_i = hold_data;
      wb_wr_ena_i  = ($urandom_range(0, 3) != 0);
      wb_rd_addr_i = 5'($urandom_range(0, 31));
      wb_rd_data_i = $urandom;
      rs1D_addr_i = 5'($urandom_range(0, 31));
      rs2D_addr_i = 5'($urandom_range(0, 31));
      rdD_addr_i  = 5'($urandom_range(0, 31));
      r = 5'($urandom_range(0, 31));
      issue_rd_i = r;
      issue_valid_i = (m_pend < 4) && ($urandom_range(0, 1) == 1) && ((r == 0) || !m_sb[r]);
      #1;

      wb_wants = wb_wr_ena_i && (wb_rd_addr_i != 0);
      forced   = m_valid && (!wb_wants || m_yield >= 4);
      e_wbst   = forced && wb_wants;
      e_mrdy   = !m_valid || forced;
      e_irdy   = m_pend < 4;
      if (forced) begin
        e_ena = (m_rd != 0); e_addr = m_rd; e_data = m_data;
      end else begin
        e_ena = wb_wants; e_addr = wb_rd_addr_i; e_data = wb_rd_data_i;
      end
      dregs[0] = rs1D_addr_i; dregs[1] = rs2D_addr_i; dregs[2] = rdD_addr_i;
      e_sbst = 0;
      foreach (dregs[i])
        if (dregs[i] != 0 && m_sb[dregs[i]] && !(forced && dregs[i] == m_rd)) e_sbst = 1;

      total++; if (rf_wr_ena_o !== e_ena)
        $display("FAIL rnd_ena c%0d: got %b want %b", cyc, rf_wr_ena_o, e_ena); else passed++;
      if (e_ena) begin
        total++; if ({rf_wr_addr_o, rf_wr_data_o} !== {e_addr, e_data})
          $display("FAIL rnd_port c%0d: got x%0d=%h want x%0d=%h", cyc, rf_wr_addr_o, rf_wr_data_o, e_addr, e_data); else passed++;
      end
      total++; if ({wb_stall_o, mdu_ready_o, issue_ready_o, sb_stall_o} !== {e_wbst, e_mrdy, e_irdy, e_sbst})
        $display("FAIL rnd_flags c%0d: got wbst/mrdy/irdy/sbst=%b want %b", cyc,
                 {wb_stall_o, mdu_ready_o, issue_ready_o, sb_stall_o}, {e_wbst, e_mrdy, e_irdy, e_sbst}); else passed++;

      if (forced) begin
        m_sb[m_rd] = 0; m_pend--; m_valid = 0; m_yield = 0;
      end else if (m_valid && m_yield < 4) begin
        m_yield++;
      end
      if (issue_valid_i) begin
        if (r != 0) m_sb[r] = 1;
        m_pend++;
        mdu_q.push_back(int'(r));
      end
      if (hold_v && e_mrdy) begin
        m_valid = 1; m_rd = hold_rd; m_data = hold_data; m_yield = 0;
        hold_v = 0;
      end
      @(negedge clk_i);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_mdu_idle();
    test_starvation();
    test_capacity();
    test_same_reg();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
